timer_counter: RTL and testbench

//  Memory-mapped down-counting timer: the responder end of the bridge's TCx port (Addr[31:2]/WE/Din/Dout).

---
 rtl/timer_counter_pkg.sv | 16 +
 rtl/timer_counter_if.sv | 10 +
 rtl/timer_counter.sv | 79 +++++++
 tb/tb_timer_counter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: register offsets, CTRL modes, FSM state encodings and bus base addresses.
package timer_counter_pkg;
    localparam logic [1:0] TC_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] TC_ADDR_PRESET = 2'd1;
    localparam logic [1:0] TC_ADDR_COUNT  = 2'd2;
    localparam logic [1:0] TC_MODE_ONESHOT    = 2'b00;
    localparam logic [1:0] TC_MODE_AUTORELOAD = 2'b01;
    localparam logic [31:0] TC0_BASE = 32'h0000_7f00;
    localparam logic [31:0] TC1_BASE = 32'h0000_7f10;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_t;
endpackage

// File: rtl/timer_counter_if.sv
// timer_counter_if: word-access register port between the bridge (master) and a timer (slave).
interface timer_counter_if;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    modport master (output Addr, output WE, output Din, input Dout, input IRQ);
    modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with one-shot/auto-reload modes and a maskable IRQ.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [3:0] CTRL_RST = 4'h0
) (
    input logic             clk,
    input logic             reset,
    timer_counter_if.slave  bus
);
    tc_state_t        state, state_n;
    logic [3:0]       ctrl, ctrl_n;
    logic [CNT_W-1:0] preset, count, count_n;
    logic             irq_flag, irq_flag_n;
    logic             wr_ctrl, wr_preset, en_clr, flag_set, flag_clr, auto_reload;
    logic             unused_addr;

    assign unused_addr = ^bus.Addr[29:2];
    assign wr_ctrl     = bus.WE && bus.Addr[1:0] == TC_ADDR_CTRL;
    assign wr_preset   = bus.WE && bus.Addr[1:0] == TC_ADDR_PRESET;
    assign auto_reload = ctrl[2:1] == TC_MODE_AUTORELOAD;

    always_comb begin
        state_n  = state;
        count_n  = count;
        en_clr   = 1'b0;
        flag_set = 1'b0;
        flag_clr = 1'b0;
        case (state)
            ST_IDLE: state_n = ctrl[0] ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                count_n = preset;
                state_n = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl[0]) begin
                    state_n = ST_IDLE;
                end else if (count > CNT_W'(1)) begin
                    count_n = count - CNT_W'(1);
                end else begin
                    count_n  = '0;
                    flag_set = 1'b1;
                    state_n  = ST_INT;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                en_clr   = !auto_reload;
                flag_clr = auto_reload;
            end
        endcase
    end

    // A CPU write to CTRL overrides the one-shot EN clear in the same cycle
    assign ctrl_n     = wr_ctrl ? bus.Din[3:0] : en_clr ? {ctrl[3:1], 1'b0} : ctrl;
    assign irq_flag_n = (wr_ctrl || wr_preset || flag_clr) ? 1'b0 : flag_set ? 1'b1 : irq_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ctrl     <= CTRL_RST;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_n;
            ctrl     <= ctrl_n;
            preset   <= wr_preset ? bus.Din[CNT_W-1:0] : preset;
            count    <= count_n;
            irq_flag <= irq_flag_n;
        end
    end

    assign bus.IRQ  = irq_flag & ctrl[3];
    assign bus.Dout = bus.Addr[1:0] == TC_ADDR_CTRL   ? {28'd0, ctrl} :
                      bus.Addr[1:0] == TC_ADDR_PRESET ? 32'(preset) :
                      bus.Addr[1:0] == TC_ADDR_COUNT  ? 32'(count) : 32'd0;
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed register/IRQ sequences with hand-computed expectations.
module tb_timer_counter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    timer_counter_if bus ();
    timer_counter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.Addr = {28'd0, a};
        #1;
        chk(tag, bus.Dout, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, bus.IRQ}, {31'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.Addr = {28'd0, a};
        bus.Din  = d;
        bus.WE   = 1'b1;
        step();
        bus.WE   = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        bus.Addr = '0;
        bus.WE   = 1'b0;
        bus.Din  = '0;
        #2;
        chk_rd("rst_ctrl", 2'd0, 32'd0);
        chk_rd("rst_preset", 2'd1, 32'd0);
        chk_rd("rst_count", 2'd2, 32'd0);
        chk_rd("rst_rsvd", 2'd3, 32'd0);
        chk_irq("rst_irq", 1'b0);
        step();
        reset = 1'b0;
        step();

        // one-shot, PRESET=5, IM set
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step();
        for (int i = 5; i >= 1; i--) begin
            step();
            chk_rd("os_count", 2'd2, 32'(i));
            chk_irq("os_irq_low", 1'b0);
        end
        step();
        chk_rd("os_count0", 2'd2, 32'd0);
        chk_irq("os_irq_set", 1'b1);
        step();
        chk_rd("os_en_clr", 2'd0, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_irq("os_irq_hold", 1'b1);
            chk_rd("os_count_hold", 2'd2, 32'd0);
        end
        wr(2'd0, 32'd0);
        chk_irq("os_irq_wrclr", 1'b0);
        step();

        // auto-reload, PRESET=3: period 6, one-cycle pulse
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 19; k++) begin
            step();
            chk_irq("ar_irq", (k % 6) == 5);
        end
        chk_rd("ar_ctrl", 2'd0, 32'hB);
        wr(2'd0, 32'd0);
        step();
        step();

        // masked flag, then CTRL write clears it
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk_irq("mask_irq", 1'b0);
        end
        chk_rd("mask_en_clr", 2'd0, 32'd0);
        wr(2'd0, 32'h9);
        chk_irq("mask_wr_irq", 1'b0);
        step();
        chk_irq("mask_wr_irq1", 1'b0);
        step();
        chk_irq("mask_wr_irq2", 1'b0);
        chk_rd("mask_count", 2'd2, 32'd2);
        wr(2'd0, 32'd0);
        step();

        // ignored COUNT/reserved writes and deferred PRESET write
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h3);
        step();
        step();
        chk_rd("ro_count6", 2'd2, 32'd6);
        wr(2'd2, 32'h1234);
        chk_rd("ro_count5", 2'd2, 32'd5);
        wr(2'd3, 32'hFFFF);
        chk_rd("ro_count4", 2'd2, 32'd4);
        chk_rd("ro_rsvd", 2'd3, 32'd0);
        wr(2'd1, 32'd2);
        chk_rd("ro_count3", 2'd2, 32'd3);
        chk_rd("ro_preset", 2'd1, 32'd2);
        step();
        chk_rd("ro_count2", 2'd2, 32'd2);
        step();
        chk_rd("ro_count1", 2'd2, 32'd1);
        for (int k = 0; k < 4; k++) step();
        chk_rd("ro_reload", 2'd2, 32'd2);
        wr(2'd0, 32'd0);
        step();

        // async reset while IRQ is high
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        for (int k = 0; k < 6; k++) step();
        chk_irq("ar2_irq", 1'b1);
        #2 reset = 1'b1;
        #1;
        chk_irq("rst_irq_async", 1'b0);
        chk_rd("rst_ctrl_async", 2'd0, 32'd0);
        chk_rd("rst_preset_async", 2'd1, 32'd0);
        step();
        reset = 1'b0;

        // async reset mid-count, no restart until EN rewritten
        wr(2'd1, 32'd7);
        wr(2'd0, 32'h1);
        step();
        step();
        step();
        chk_rd("mid_count", 2'd2, 32'd6);
        bus.Addr = 30'd2;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count", bus.Dout, 32'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk_rd("mid_no_restart", 2'd2, 32'd0);
        chk_rd("mid_ctrl0", 2'd0, 32'd0);

        // PRESET=1 and the CTRL-write vs EN-clear collision
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        step();
        step();
        step();
        wr(2'd0, 32'h9);
        chk_rd("coll_ctrl", 2'd0, 32'h9);
        chk_irq("coll_irq", 1'b0);
        wr(2'd0, 32'd0);
        step();

        // PRESET=0: IRQ 3 cycles after EN write
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step();
        step();
        chk_irq("p0_irq_early", 1'b0);
        step();
        chk_irq("p0_irq", 1'b1);
        chk_rd("p0_count", 2'd2, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
